// File: rtl/axis_pkg.sv
// Shared definitions for the packed AXI-Stream width converters.
// Holds default widths, word/beat types, the FSM state type and a ceiling-divide helper.
package axis_pkg;

    function automatic int unsigned CEIL(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

    localparam int unsigned DEF_WORD_W         = 8;
    localparam int unsigned DEF_BUS_W          = 32;
    localparam int unsigned DEF_WORDS_PER_BEAT = CEIL(DEF_BUS_W, DEF_WORD_W);

    typedef logic [DEF_WORD_W-1:0]                         word_t;
    typedef logic [DEF_WORDS_PER_BEAT-1:0][DEF_WORD_W-1:0] beat_t;

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } unpack_state_t;

endpackage

// File: rtl/axis_unpacker_if.sv
// Bus bundle for axis_unpacker: wide packed slave stream in, single-word master stream out.
// The slave modport is the converter's view; master is the surrounding environment's view.
interface axis_unpacker_if
    import axis_pkg::*;
#(
    parameter int unsigned WORD_W         = DEF_WORD_W,
    parameter int unsigned WORDS_PER_BEAT = DEF_WORDS_PER_BEAT
) ();

    logic                             s_valid;
    logic                             s_ready;
    logic                             s_last;
    logic [WORDS_PER_BEAT-1:0]        s_keep;
    logic [WORDS_PER_BEAT*WORD_W-1:0] s_data;
    logic                             m_valid;
    logic                             m_ready;
    logic                             m_last;
    logic [WORD_W-1:0]                m_data;
    logic                             err_null_last;

    modport slave (
        input  s_valid, s_last, s_keep, s_data, m_ready,
        output s_ready, m_valid, m_last, m_data, err_null_last
    );

    modport master (
        output s_valid, s_last, s_keep, s_data, m_ready,
        input  s_ready, m_valid, m_last, m_data, err_null_last
    );

endinterface

// File: rtl/axis_unpacker_lsb_onehot.sv
// Lowest-set-bit encoder: onehot of the lowest set bit, its index,
// and whether the vector has any / exactly one bit set.
module lsb_onehot #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             single
);

    assign onehot = vec & (~vec + N'(1));
    assign any    = |vec;
    assign single = any & ~(|(vec & (vec - N'(1))));

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/axis_unpacker.sv
// Wide-to-word AXI-Stream unpacker: emits the kept lanes of each beat one per cycle
// in lane order, marking the final kept word of the packet with m_last.
module axis_unpacker
    import axis_pkg::*;
#(
    parameter int unsigned WORD_W         = DEF_WORD_W,
    parameter int unsigned BUS_W          = DEF_BUS_W,
    parameter int unsigned WORDS_PER_BEAT = CEIL(BUS_W, WORD_W)
) (
    input  logic            clk,
    input  logic            rstn,
    axis_unpacker_if.slave  bus
);

    localparam int unsigned IDX_W = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;

    typedef logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] lanes_t;

    unpack_state_t             state_q, state_d;
    lanes_t                    data_q, data_d;
    logic [WORDS_PER_BEAT-1:0] keep_q, keep_d;
    logic                      last_q, last_d;
    logic                      null_d;
    logic                      s_ready_c;

    logic [WORD_W-1:0]         m_data_q;
    logic                      m_last_q;
    logic                      err_q;

    logic [WORDS_PER_BEAT-1:0] cur_onehot, nxt_onehot;
    logic [IDX_W-1:0]          cur_idx, nxt_idx;
    logic                      cur_any, nxt_any;
    logic                      cur_single, nxt_single;

    // Encoder on the held mask: selects the lane to clear and flags the last word of the beat.
    lsb_onehot #(.N(WORDS_PER_BEAT), .IDX_W(IDX_W)) u_cur (
        .vec    (keep_q),
        .onehot (cur_onehot),
        .idx    (cur_idx),
        .any    (cur_any),
        .single (cur_single)
    );

    // Encoder on the next mask: lets the output word and m_last be registered directly.
    lsb_onehot #(.N(WORDS_PER_BEAT), .IDX_W(IDX_W)) u_nxt (
        .vec    (keep_d),
        .onehot (nxt_onehot),
        .idx    (nxt_idx),
        .any    (nxt_any),
        .single (nxt_single)
    );

    logic unused_enc;
    assign unused_enc = ^{cur_idx, cur_any, nxt_onehot};

    always_comb begin
        keep_d    = keep_q;
        data_d    = data_q;
        last_d    = last_q;
        null_d    = 1'b0;
        s_ready_c = 1'b0;

        case (state_q)
            EMPTY: s_ready_c = 1'b1;
            DRAIN: begin
                // The final word and the next beat hand over in the same cycle.
                s_ready_c = bus.m_ready & cur_single;
                if (bus.m_ready) keep_d = keep_q & ~cur_onehot;
            end
        endcase

        // Null beats are swallowed; only a null beat carrying last is flagged.
        if (bus.s_valid && s_ready_c) begin
            if (|bus.s_keep) begin
                keep_d = bus.s_keep;
                data_d = bus.s_data;
                last_d = bus.s_last;
            end else begin
                null_d = bus.s_last;
            end
        end

        state_d = nxt_any ? DRAIN : EMPTY;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= EMPTY;
            keep_q   <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            m_data_q <= '0;
            m_last_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            keep_q   <= keep_d;
            data_q   <= data_d;
            last_q   <= last_d;
            m_data_q <= data_d[nxt_idx];
            m_last_q <= last_d & nxt_single;
            err_q    <= null_d;
        end
    end

    assign bus.s_ready       = s_ready_c;
    assign bus.m_valid       = (state_q == DRAIN);
    assign bus.m_data        = m_data_q;
    assign bus.m_last        = m_last_q;
    assign bus.err_null_last = err_q;

endmodule

// File: tb/tb_axis_unpacker.sv
// Scoreboard bench for axis_unpacker: beats are expanded into expected words at
// acceptance time, and a monitor compares every transferred word against the queue.
module tb_axis_unpacker;
    import axis_pkg::*;

    localparam int unsigned WPB = DEF_WORDS_PER_BEAT;
    localparam int unsigned WW  = DEF_WORD_W;

    typedef struct packed {
        word_t data;
        logic  last;
        logic  beat_end;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axis_unpacker_if bus ();

    axis_unpacker dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    exp_t  exp_q[$];
    int    n_tests   = 0;
    int    n_fail    = 0;
    int    cyc       = 0;
    int    ready_pct = 100;
    int    err_due   = -1;
    bit    prev_stall = 1'b0;
    word_t prev_data;
    logic  prev_last;
    bit    tp_on = 1'b0;
    int    tp_cnt, tp_first, tp_last, tp_acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
        end
    end

    // Monitor: word-level scoreboard, stall stability, error pulse and idle readiness.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.err_null_last === 1'b1 || cyc == err_due)
                chk("err_null_last", bus.err_null_last, (cyc == err_due));
            if (prev_stall)
                chk("stall_hold", {bus.m_valid, bus.m_last, bus.m_data}, {1'b1, prev_last, prev_data});
            if (!bus.m_valid)
                chk("idle_s_ready", bus.s_ready, 1);
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word (cycle %0d)", bus.m_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", bus.m_data, e.data);
                    chk("m_last", bus.m_last, e.last);
                    chk("s_ready_beat_end", bus.s_ready, e.beat_end);
                    if (tp_on) begin
                        if (tp_cnt == 0) tp_first = cyc;
                        tp_last = cyc;
                        tp_cnt++;
                    end
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
        end
    end

    // Reference: a beat yields its kept lanes in ascending order; the highest kept lane ends the beat.
    task automatic model_beat(input logic [WPB-1:0] keep, input logic [DEF_BUS_W-1:0] data, input bit last);
        int   hi;
        exp_t e;
        hi = -1;
        for (int i = 0; i < int'(WPB); i++) if (keep[i]) hi = i;
        for (int i = 0; i < int'(WPB); i++) begin
            if (keep[i]) begin
                e.data     = data[i*WW +: WW];
                e.last     = last && (i == hi);
                e.beat_end = (i == hi);
                exp_q.push_back(e);
            end
        end
        if (hi < 0 && last) err_due = cyc + 1;
        if (tp_on && tp_acc < 0) tp_acc = cyc;
    endtask

    task automatic send_beat(input logic [WPB-1:0] keep, input logic [DEF_BUS_W-1:0] data,
                             input bit last, input int pct);
        logic [DEF_BUS_W-1:0] d;
        int guard;
        while (pct < 100 && $urandom_range(99) >= pct) begin
            @(posedge clk);
            #1;
        end
        d = data;
        for (int i = 0; i < int'(WPB); i++) if (!keep[i]) d[i*WW +: WW] = 'x;
        bus.s_valid = 1'b1;
        bus.s_keep  = keep;
        bus.s_data  = d;
        bus.s_last  = last;
        guard = 0;
        forever begin
            @(negedge clk);
            if (rstn && bus.s_ready) begin
                model_beat(keep, data, last);
                break;
            end
            guard++;
            if (guard > 20000) begin
                n_tests++;
                n_fail++;
                $display("FAIL s_handshake_timeout: got no s_ready, expected acceptance (cycle %0d)", cyc);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_keep  = '0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_packet(input int n, input int pct);
        int rem, kmax, k;
        logic [WPB-1:0] m;
        rem = n;
        while (rem > 0) begin
            kmax = (rem < int'(WPB)) ? rem : int'(WPB);
            k = int'($urandom_range(kmax, 1));
            do m = WPB'($urandom_range((1 << WPB) - 1, 1)); while ($countones(m) != k);
            if ($urandom_range(19) == 0) send_beat('0, $urandom, 1'b0, pct);
            rem -= k;
            send_beat(m, $urandom, (rem == 0), pct);
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 || bus.m_valid) begin
            @(negedge clk);
            guard++;
            if (guard > 50000) begin
                n_tests++;
                n_fail++;
                $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, expected finish before %0t", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
        $fatal(1);
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_keep  = '0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_m_valid", bus.m_valid, 0);
        chk("reset_m_last", bus.m_last, 0);
        chk("reset_err", bus.err_null_last, 0);
        chk("reset_s_ready", bus.s_ready, 1);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Single full beat, then a sparse beat followed by a one-word last beat.
        send_beat(4'b1111, 32'h44332211, 1'b1, 100);
        wait_drain();
        send_beat(4'b1010, 32'hBB00AA00, 1'b0, 100);
        send_beat(4'b0001, 32'h000000CC, 1'b1, 100);
        wait_drain();

        // Null-last beat after a partial beat.
        send_beat(4'b0011, $urandom, 1'b0, 100);
        send_beat(4'b0000, $urandom, 1'b1, 100);
        wait_drain();
        repeat (3) @(posedge clk);
        #1;

        // Reset after two of four words have transferred.
        send_beat(4'b1111, $urandom, 1'b1, 100);
        @(posedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("midreset_m_valid", bus.m_valid, 0);
        chk("midreset_s_ready", bus.s_ready, 1);
        chk("midreset_words_left", exp_q.size(), 2);
        exp_q.delete();
        err_due = -1;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        send_packet(int'($urandom_range(20, 5)), 100);
        wait_drain();

        // Eight back-to-back full beats.
        tp_on  = 1'b1;
        tp_cnt = 0;
        tp_acc = -1;
        for (int b = 0; b < 8; b++) send_beat(4'b1111, $urandom, (b == 7), 100);
        wait_drain();
        tp_on = 1'b0;
        chk("tp_words", tp_cnt, 32);
        chk("tp_span", tp_last - tp_first, 31);
        chk("tp_latency", tp_first - tp_acc, 1);

        // Heavy backpressure and sparse valid.
        ready_pct = 10;
        send_beat(4'b1111, $urandom, 1'b0, 1);
        send_beat(4'b1111, $urandom, 1'b0, 1);
        send_beat(4'b0011, $urandom, 1'b1, 1);
        for (int p = 0; p < 20; p++) send_packet(int'($urandom_range(100, 1)), 1);
        wait_drain();
        ready_pct = 100;
        repeat (3) @(posedge clk);
        #1;

        chk("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
